// File: rtl/conv2d_image_loader_pkg.sv
// Shared definitions for the conv2d image loader and the related frame walkers.
// Sizes here are the default build; modules derive their own from their parameters.
package conv2d_image_loader_pkg;

    localparam int DEF_BITWIDTH     = 8;
    localparam int DEF_IMAGE_WIDTH  = 28;
    localparam int DEF_IMAGE_HEIGHT = 28;
    localparam int DEF_IN_CHANNEL   = 1;

    localparam int FRAME_PIXELS = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT * DEF_IN_CHANNEL;
    localparam int IMAGE_BITS   = FRAME_PIXELS * DEF_BITWIDTH;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } loader_state_e;

    // $clog2 that never returns 0, so a size-1 dimension still gets a real bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int frame_pixels(input int w, input int h, input int c);
        return w * h * c;
    endfunction

endpackage

// File: rtl/conv2d_image_loader_pixel_counter.sv
// Nested x/y/c position counter for walking a frame in channel, row, column order.
// Advances one pixel per adv_i and wraps back to the origin after the last pixel.
module conv2d_pixel_counter
    import conv2d_image_loader_pkg::*;
#(
    parameter int WIDTH    = 28,
    parameter int HEIGHT   = 28,
    parameter int CHANNELS = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          adv_i,
    output logic [cnt_w(WIDTH)-1:0]       x_o,
    output logic [cnt_w(HEIGHT)-1:0]      y_o,
    output logic [cnt_w(CHANNELS)-1:0]    c_o,
    output logic                          last_o
);

    localparam int XW = cnt_w(WIDTH);
    localparam int YW = cnt_w(HEIGHT);
    localparam int CW = cnt_w(CHANNELS);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] c_q, c_d;
    logic          x_end, y_end, c_end;

    assign x_end  = (x_q == XW'(WIDTH - 1));
    assign y_end  = (y_q == YW'(HEIGHT - 1));
    assign c_end  = (c_q == CW'(CHANNELS - 1));
    assign last_o = x_end && y_end && c_end;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        c_d = c_q;
        if (adv_i) begin
            if (!x_end) begin
                x_d = x_q + 1'b1;
            end else begin
                x_d = '0;
                if (!y_end) begin
                    y_d = y_q + 1'b1;
                end else begin
                    y_d = '0;
                    c_d = c_end ? '0 : c_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            c_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            c_q <= c_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
    assign c_o = c_q;

endmodule

// File: rtl/conv2d_image_loader.sv
// Packs a valid/ready pixel stream into a flat multi-channel image, presents it to the
// conv cores until they signal done, then reopens for the next frame.
module conv2d_image_loader
    import conv2d_image_loader_pkg::*;
#(
    parameter int BITWIDTH     = DEF_BITWIDTH,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int IN_CHANNEL   = DEF_IN_CHANNEL,
    parameter int CHECK_LAST   = 1
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic                                                      s_valid,
    output logic                                                      s_ready,
    input  logic signed [BITWIDTH-1:0]                                s_data,
    input  logic                                                      s_last,
    output logic                                                      image_valid,
    input  logic                                                      calc_done,
    output logic [IN_CHANNEL*IMAGE_WIDTH*IMAGE_HEIGHT*BITWIDTH-1:0]   image,
    output logic                                                      busy,
    output logic                                                      frame_err
);

    localparam int FP = frame_pixels(IMAGE_WIDTH, IMAGE_HEIGHT, IN_CHANNEL);
    localparam int IB = FP * BITWIDTH;
    localparam int IW = cnt_w(FP);

    loader_state_e state_q, state_d;

    logic [cnt_w(IMAGE_WIDTH)-1:0]  x;
    logic [cnt_w(IMAGE_HEIGHT)-1:0] y;
    logic [cnt_w(IN_CHANNEL)-1:0]   c;
    logic                           last_pix;
    logic                           xfer;
    logic [IW-1:0]                  idx;

    logic          calc_done_q;
    logic          busy_q;
    logic          err_q;
    logic [IB-1:0] image_q;

    assign xfer = s_valid && s_ready;

    // The final transfer wraps the counter to the origin, which is the counter clear.
    conv2d_pixel_counter #(
        .WIDTH    (IMAGE_WIDTH),
        .HEIGHT   (IMAGE_HEIGHT),
        .CHANNELS (IN_CHANNEL)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .adv_i  (xfer),
        .x_o    (x),
        .y_o    (y),
        .c_o    (c),
        .last_o (last_pix)
    );

    assign idx = IW'(32'(c) * (IMAGE_WIDTH * IMAGE_HEIGHT) + 32'(y) * IMAGE_WIDTH + 32'(x));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:    if (xfer && last_pix) state_d = ST_HOLD;
            ST_HOLD:    if (calc_done && !calc_done_q) state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_LOAD;
            default:    state_d = ST_LOAD;
        endcase
    end

    // Ready is masked during the reset cycle itself so nothing is offered before it lifts.
    always_comb begin
        s_ready     = (state_q == ST_LOAD) && !rst;
        image_valid = (state_q == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            calc_done_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            image_q     <= '0;
        end else begin
            // Zeroing on HOLD entry lets a done level that is already high count as an edge.
            if (state_q != ST_HOLD && state_d == ST_HOLD) calc_done_q <= 1'b0;
            else                                          calc_done_q <= calc_done;

            if (state_d == ST_RELEASE) busy_q <= 1'b0;
            else if (xfer)             busy_q <= 1'b1;

            if (xfer) image_q[idx*BITWIDTH +: BITWIDTH] <= s_data;

            if (CHECK_LAST != 0 && xfer && (s_last != last_pix)) err_q <= 1'b1;
        end
    end

    assign image     = image_q;
    assign busy      = busy_q;
    assign frame_err = (CHECK_LAST != 0) ? err_q : 1'b0;

endmodule
